mem_cache_op_ctrl: RTL and testbench
====================================

// Module: mem_cache_op_ctrl
// PURPOSE
//  Sequences MIPS CACHE instructions that reach the MEM stage. It latches the op and address,
//  drives a req/ok handshake into the I-cache or D-cache, and holds the MEM stage busy until
//  completion. It then presents a completion level to WB.
//  Sits beside the MEM stage; its busy output gates MEM readiness the same way data_data_ok
//  does for loads and stores.
// PARAMETERS
//  OP_W    5   width of cache op field; bits[1:0] select target (00=I, 01=D, others=no-op)
//  ADDR_W  32  width of cache op address
// PORTS
//  clk           in   1       clock; single clock domain
//  rst           in   1       synchronous, active-high reset
//  req_valid     in   1       MEM holds a valid, exception-free CACHE instruction
//  req_op        in   OP_W    cache operator from MEM
//  req_addr      in   ADDR_W  cache address from MEM (aluRes)
//  flush         in   1       CP0 flush of the MEM stage (excOccur && exceptSeg[MEM])
//  wb_allowin    in   1       WB can accept MEM's instruction this cycle
//  busy          out  1       MEM must not complete/advance this cycle
//  done          out  1       CACHE op finished; MEM may hand instruction to WB
//  icache_req    out  1       I-cache op request, held until icache_ok
//  icache_op     out  OP_W    latched op to I-cache
//  icache_addr   out  ADDR_W  latched address to I-cache
//  icache_ok     in   1       I-cache accepts and finishes op (single-cycle pulse)
//  dcache_req    out  1       D-cache op request, held until dcache_ok
//  dcache_op     out  OP_W    latched op to D-cache
//  dcache_addr   out  ADDR_W  latched address to D-cache
//  dcache_ok     in   1       D-cache finishes op, including any writeback (single-cycle pulse)
// BEHAVIOUR
//  Reset and start-up
//  - Reset: state=IDLE, kill=0, op_r=0, addr_r=0; all outputs 0.
//  - rst wins over every other input in the same cycle.
//  - rst in REQ_I/REQ_D drops the req line on the next edge; the cache is reset together
//    with this block.
//  States: IDLE, REQ_I, REQ_D, DONE.
//  - IDLE, req_valid && !flush:
//    - latch op_r<=req_op, addr_r<=req_addr;
//    - go to REQ_I if op[1:0]==00, REQ_D if op[1:0]==01, otherwise DONE (no cache access).
//  - REQ_I/REQ_D:
//    - the matching *_req=1 with *_op=op_r and *_addr=addr_r, stable until *_ok;
//    - the other cache's req is always 0.
//    - *_ok sampled high -> DONE if kill==0, else IDLE with kill cleared.
//    - ok in the same cycle req first rises is legal: one-cycle request.
//  - DONE:
//    - done=1 (level);
//    - wb_allowin=1 -> IDLE;
//    - flush=1 -> IDLE with done forced 0 that cycle.
//  Flush
//  - flush in IDLE: nothing latched.
//  - flush in REQ_*: a request is never withdrawn. Set kill=1, keep req until ok, then return
//    silently with no done.
//  - flush in DONE: drop to IDLE.
//  busy (combinational)
//  - (IDLE && req_valid && !flush) || REQ_I || REQ_D || (DONE && !wb_allowin && !flush).
//  - Minimum latency, request to done: 2 cycles (IDLE->REQ with ok->DONE).
//  - No-op target: done 1 cycle after acceptance.
//  - After DONE->IDLE, req_valid in that next cycle is a new instruction. No re-issue guard
//    is needed because MEM advances on the DONE&&wb_allowin edge.
//  Other rules
//  - Ignore icache_ok/dcache_ok outside the matching REQ state.
//  - At most one outstanding op; I and D requests are never concurrent.
// TESTING
//  1. D op 5'b00101, addr 0x8000_1040, dcache_ok 3 cycles after req -> dcache_req high 3
//     cycles with op/addr stable; done=1 next cycle; busy=0 once wb_allowin=1.
//  2. I op 5'b00000, addr 0x9FC0_0000, icache_ok in the first req cycle -> icache_req 1 cycle;
//     done 1 cycle later; dcache_req stays 0.
//  3. D op, flush in 2nd REQ_D cycle, ok at cycle 4 -> dcache_req held through cycle 4; done
//     never asserts; state IDLE after ok.
//  4. op[1:0]=2'b10 -> no icache/dcache req; done=1 next cycle.
//  5. rst asserted mid REQ_I -> icache_req=0, busy=0, done=0 next cycle; a new I op issues
//     normally afterward.
//  6. DONE with wb_allowin low 2 cycles -> done and busy held 2 cycles; IDLE on the
//     wb_allowin=1 edge.

Source files
------------

// File: rtl/mem_cache_op_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_cache_op_ctrl_if
// Groups the signals of the MIPS CACHE-instruction sequencer into one
// bundle: the MEM-stage request side, the pipeline control side (flush,
// wb_allowin, busy, done) and the two cache request/ok handshakes.
//
//   req_valid   MEM holds a valid, exception-free CACHE instruction
//   req_op      cache operator; bits[1:0] choose I (00), D (01) or no-op
//   req_addr    cache address from MEM
//   flush       CP0 flush of the MEM stage
//   wb_allowin  WB can accept MEM's instruction this cycle
//   busy        MEM must not complete/advance this cycle
//   done        CACHE op finished, MEM may hand the instruction to WB
//   icache_*    request/op/address to the I-cache, icache_ok back
//   dcache_*    request/op/address to the D-cache, dcache_ok back
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding pipeline and caches
// ---------------------------------------------------------------------------
interface mem_cache_op_ctrl_if #(
  parameter int OP_W   = 5,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic [OP_W-1:0]   req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              wb_allowin;
  logic              busy;
  logic              done;
  logic              icache_req;
  logic [OP_W-1:0]   icache_op;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_ok;
  logic              dcache_req;
  logic [OP_W-1:0]   dcache_op;
  logic [ADDR_W-1:0] dcache_addr;
  logic              dcache_ok;

  // View from the sequencer
  modport slave (
    input  req_valid, req_op, req_addr, flush, wb_allowin,
    input  icache_ok, dcache_ok,
    output busy, done,
    output icache_req, icache_op, icache_addr,
    output dcache_req, dcache_op, dcache_addr
  );

  // View from the pipeline and the caches
  modport master (
    output req_valid, req_op, req_addr, flush, wb_allowin,
    output icache_ok, dcache_ok,
    input  busy, done,
    input  icache_req, icache_op, icache_addr,
    input  dcache_req, dcache_op, dcache_addr
  );

endinterface

// File: rtl/mem_cache_op_ctrl.sv
// ---------------------------------------------------------------------------
// mem_cache_op_ctrl
// Sequences MIPS CACHE instructions that reach the MEM stage. The op and
// address are latched when the instruction is accepted, a request is held
// on the selected cache until that cache answers with ok, and MEM is kept
// busy meanwhile. Completion is then presented to WB as a level on done
// until WB takes the instruction or the stage is flushed.
//
// Ports:
//   clk      single clock
//   rst      synchronous, active-high reset
//   ctrlBus  mem_cache_op_ctrl_if.slave (MEM request, pipeline control,
//            I-cache and D-cache handshakes)
//
// Flow: IDLE -> REQ_I / REQ_D / DONE -> DONE -> IDLE.
// A flush while a cache request is outstanding cannot withdraw the request;
// it only marks the op as killed so that it ends silently without done.
// ---------------------------------------------------------------------------
module mem_cache_op_ctrl #(
  parameter int OP_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_cache_op_ctrl_if.slave    ctrlBus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_I = 2'd1,
    REQ_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_kill;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_icacheReq;
  logic              r_dcacheReq;

  logic              w_accept;
  logic [1:0]        w_target;
  logic              w_reqState;
  logic              w_doneHold;

  // A new CACHE instruction is taken only from IDLE and only when the stage
  // is not being flushed in the same cycle.
  assign w_accept = (r_state == IDLE) && ctrlBus.req_valid && !ctrlBus.flush;
  assign w_target = ctrlBus.req_op[1:0];

  // Main sequencer. The cache request lines are registered alongside the
  // state so they rise exactly on entry to REQ_I/REQ_D and fall on the edge
  // where the matching ok is seen. An ok arriving in the first request cycle
  // is legal and produces a one-cycle request. A flush coinciding with the
  // ok is treated like an earlier flush: the instruction is gone from MEM,
  // so no done may be raised for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_kill      <= 1'b0;
      r_op        <= '0;
      r_addr      <= '0;
      r_icacheReq <= 1'b0;
      r_dcacheReq <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= ctrlBus.req_op;
            r_addr <= ctrlBus.req_addr;
            unique case (w_target)
              2'b00: begin
                r_state     <= REQ_I;
                r_icacheReq <= 1'b1;
              end
              2'b01: begin
                r_state     <= REQ_D;
                r_dcacheReq <= 1'b1;
              end
              default: begin
                r_state <= DONE;
              end
            endcase
          end
        end

        REQ_I: begin
          if (ctrlBus.icache_ok) begin
            r_icacheReq <= 1'b0;
            r_kill      <= 1'b0;
            if (r_kill || ctrlBus.flush) begin
              r_state <= IDLE;
            end else begin
              r_state <= DONE;
            end
          end else if (ctrlBus.flush) begin
            r_kill <= 1'b1;
          end
        end

        REQ_D: begin
          if (ctrlBus.dcache_ok) begin
            r_dcacheReq <= 1'b0;
            r_kill      <= 1'b0;
            if (r_kill || ctrlBus.flush) begin
              r_state <= IDLE;
            end else begin
              r_state <= DONE;
            end
          end else if (ctrlBus.flush) begin
            r_kill <= 1'b1;
          end
        end

        DONE: begin
          if (ctrlBus.flush || ctrlBus.wb_allowin) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Busy mirrors the data_ok gating of loads/stores: MEM stalls while an op
  // is being accepted or is outstanding, and while a finished op waits for
  // WB. A flush releases the stall because the instruction is discarded.
  assign w_reqState = (r_state == REQ_I) || (r_state == REQ_D);
  assign w_doneHold = (r_state == DONE) && !ctrlBus.wb_allowin && !ctrlBus.flush;
  assign ctrlBus.busy = w_accept || w_reqState || w_doneHold;

  // Done is a level while in DONE, suppressed in the cycle of a flush.
  assign ctrlBus.done = (r_state == DONE) && !ctrlBus.flush;

  assign ctrlBus.icache_req  = r_icacheReq;
  assign ctrlBus.icache_op   = r_op;
  assign ctrlBus.icache_addr = r_addr;
  assign ctrlBus.dcache_req  = r_dcacheReq;
  assign ctrlBus.dcache_op   = r_op;
  assign ctrlBus.dcache_addr = r_addr;

endmodule

// File: tb/tb_mem_cache_op_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_cache_op_ctrl
// Directed bench for the CACHE-instruction sequencer. Every accepted op that
// must reach a cache is pushed into a scoreboard queue; a monitor pops it
// when the matching request line rises and checks target, op and address,
// and keeps checking that op/address stay stable while the request is held.
// Cycle-level busy/done/req expectations are checked from the main thread.
// ---------------------------------------------------------------------------
module tb_mem_cache_op_ctrl;

  localparam int OP_W   = 5;
  localparam int ADDR_W = 32;

  typedef struct {
    logic              isD;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } sbEntry_t;

  logic clk;
  logic rst;

  int vecCount = 0;
  int errCount = 0;

  sbEntry_t sbQueue[$];
  sbEntry_t curEntry;
  logic     prevIReq;
  logic     prevDReq;

  mem_cache_op_ctrl_if #(.OP_W(OP_W), .ADDR_W(ADDR_W)) bus ();

  mem_cache_op_ctrl #(.OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrlBus (bus.slave)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then settle
  task automatic applyStimulus(input logic valid, input logic [OP_W-1:0] op,
                               input logic [ADDR_W-1:0] addr, input logic fl,
                               input logic wbAllow, input logic iOk,
                               input logic dOk, input logic rstV);
    @(posedge clk);
    #1;
    rst            = rstV;
    bus.req_valid  = valid;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.flush      = fl;
    bus.wb_allowin = wbAllow;
    bus.icache_ok  = iOk;
    bus.dcache_ok  = dOk;
    #1;
  endtask

  // Accept a new op and record what the caches should later see
  task automatic issueOp(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr);
    sbEntry_t e;
    if (op[1:0] == 2'b00 || op[1:0] == 2'b01) begin
      e.isD  = (op[1:0] == 2'b01);
      e.op   = op;
      e.addr = addr;
      sbQueue.push_back(e);
    end
    applyStimulus(1'b1, op, addr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkSignals(input string tag, input logic busyE, input logic doneE,
                              input logic iReqE, input logic dReqE);
    checkOutput({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, busyE});
    checkOutput({tag, ".done"}, {31'd0, bus.done}, {31'd0, doneE});
    checkOutput({tag, ".icache_req"}, {31'd0, bus.icache_req}, {31'd0, iReqE});
    checkOutput({tag, ".dcache_req"}, {31'd0, bus.dcache_req}, {31'd0, dReqE});
  endtask

  // Scoreboard monitor: pops on each request rising edge, checks stability
  // of op/address while a request is held, and flags concurrent requests.
  always @(negedge clk) begin
    if (bus.icache_req && bus.dcache_req) begin
      checkOutput("sbBothReq", 32'd1, 32'd0);
    end
    if ((bus.icache_req && !prevIReq) || (bus.dcache_req && !prevDReq)) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sbUnexpectedReq", 32'd1, 32'd0);
      end else begin
        curEntry = sbQueue.pop_front();
        checkOutput("sbTarget", {31'd0, bus.dcache_req}, {31'd0, curEntry.isD});
      end
    end
    if (bus.icache_req) begin
      checkOutput("sbIOp", {27'd0, bus.icache_op}, {27'd0, curEntry.op});
      checkOutput("sbIAddr", bus.icache_addr, curEntry.addr);
    end
    if (bus.dcache_req) begin
      checkOutput("sbDOp", {27'd0, bus.dcache_op}, {27'd0, curEntry.op});
      checkOutput("sbDAddr", bus.dcache_addr, curEntry.addr);
    end
    prevIReq <= bus.icache_req;
    prevDReq <= bus.dcache_req;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prevIReq       = 1'b0;
    prevDReq       = 1'b0;
    curEntry.isD   = 1'b0;
    curEntry.op    = '0;
    curEntry.addr  = '0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.flush      = 1'b0;
    bus.wb_allowin = 1'b0;
    bus.icache_ok  = 1'b0;
    bus.dcache_ok  = 1'b0;

    // Reset state
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.icache_op", {27'd0, bus.icache_op}, 32'd0);
    checkOutput("reset.dcache_addr", bus.dcache_addr, 32'd0);

    // Flush in IDLE with a valid request: nothing accepted, stray ok ignored
    applyStimulus(1'b1, 5'b00001, 32'h1111_2220, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSignals("idleFlush", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("idleFlushAfter", 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: D op, ok on the third request cycle, WB waits one cycle
    $display("[TB] test 1: D op with 3-cycle request");
    issueOp(5'b00101, 32'h8000_1040);
    checkSignals("t1.accept", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkSignals("t1.req", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSignals("t1.reqOk", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t1.doneWait", 1'b1, 1'b1, 1'b0, 1'b0);
    bus.wb_allowin = 1'b1;
    #1;
    checkSignals("t1.doneAllow", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: I op with ok in the first request cycle
    $display("[TB] test 2: I op with one-cycle request");
    issueOp(5'b00000, 32'h9FC0_0000);
    checkSignals("t2.accept", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkSignals("t2.reqOk", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSignals("t2.done", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: D op flushed in its 2nd request cycle, ok in the 4th
    $display("[TB] test 3: flush during D request");
    issueOp(5'b00001, 32'h1234_5670);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t3.req1", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t3.req2Flush", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t3.req3", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSignals("t3.req4Ok", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSignals("t3.silent", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: no-op target, done one cycle after acceptance
    $display("[TB] test 4: no-op target");
    issueOp(5'b00010, 32'h0000_0100);
    checkSignals("t4.accept", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSignals("t4.done", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: reset in the middle of an I request, then a normal I op
    $display("[TB] test 5: reset during I request");
    issueOp(5'b00100, 32'hBFC0_0180);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkSignals("t5.reqRst", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t5.afterRst", 1'b0, 1'b0, 1'b0, 1'b0);
    issueOp(5'b01000, 32'h0000_0040);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkSignals("t5.reqOk", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSignals("t5.done", 1'b0, 1'b1, 1'b0, 1'b0);

    // 6: WB stalls two cycles in DONE
    $display("[TB] test 6: WB stall in DONE");
    issueOp(5'b01001, 32'h8000_2000);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkSignals("t6.reqOk", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkSignals("t6.stall", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkSignals("t6.release", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush while in DONE: done suppressed that cycle, back to IDLE
    $display("[TB] test 7: flush in DONE");
    issueOp(5'b11111, 32'h0000_0200);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t7.flushDone", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkSignals("t7.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Every expected cache request must have been observed
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sbDrained", sbQueue.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
